// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: shared types and defaults for the CPU I/O bridge.
//   io_state_t    - input-request FSM states (IDLE, WAIT, RESP)
//   DEFAULT_WIDTH - default data word width
//   DEFAULT_DEPTH - default FIFO depth (power of two, >= 2)
package io_bridge_pkg;

    localparam int unsigned DEFAULT_WIDTH = 64;
    localparam int unsigned DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } io_state_t;

endpackage

// File: rtl/io_fifo.sv
// io_fifo: synchronous first-word-fall-through FIFO.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   push, push_data   - write request and word; accepted when not full, or when full
//                       together with a pop that frees the slot
//   pop               - read request; ignored while empty
//   head_data         - current head word (0 while empty)
//   empty, full       - occupancy flags
module io_fifo
    import io_bridge_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(DEPTH));

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Gate the head so an empty FIFO presents zero rather than stale storage.
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the empty gate on head_data hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/cpu_io_bridge.sv
// cpu_io_bridge: host-side counterpart of the CPU in/out I/O ports.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   out_signal, out_data            - CPU output strobe/word, captured into the output FIFO
//   in_req                          - CPU request for one input word (pulse)
//   in_signal, in_data              - one-cycle response strobe and held response word
//   halt                            - CPU halted; abandons a pending request
//   host_out_valid/data/ready       - output FIFO drain stream (FWFT head)
//   host_in_valid/data, host_in_ready - input FIFO fill stream
//   out_overflow                    - sticky: a CPU word was dropped on a full output FIFO
// Optional (macro IO_BRIDGE_STATS_EN):
//   out_word_count, in_word_count   - accepted-output and delivered-input word counters
module cpu_io_bridge
    import io_bridge_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             out_signal,
    input  logic [WIDTH-1:0] out_data,
    input  logic             in_req,
    output logic             in_signal,
    output logic [WIDTH-1:0] in_data,
    input  logic             halt,
    output logic             host_out_valid,
    output logic [WIDTH-1:0] host_out_data,
    input  logic             host_out_ready,
    input  logic             host_in_valid,
    input  logic [WIDTH-1:0] host_in_data,
    output logic             host_in_ready,
`ifdef IO_BRIDGE_STATS_EN
    output logic [31:0]      out_word_count,
    output logic [31:0]      in_word_count,
`endif
    output logic             out_overflow
);

    logic             out_empty, out_full;
    logic             in_empty, in_full;
    logic [WIDTH-1:0] in_head;
    logic             in_pop;
    logic             out_accept;

    io_state_t        state_q, state_d;
    logic [WIDTH-1:0] in_data_q, in_data_d;
    logic             overflow_q;

    io_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (out_signal),
        .push_data(out_data),
        .pop      (host_out_ready),
        .head_data(host_out_data),
        .empty    (out_empty),
        .full     (out_full)
    );

    io_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_in_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (host_in_valid && host_in_ready),
        .push_data(host_in_data),
        .pop      (in_pop),
        .head_data(in_head),
        .empty    (in_empty),
        .full     (in_full)
    );

    assign host_out_valid = !out_empty;
    assign host_in_ready  = !in_full;
    assign in_signal      = (state_q == RESP);
    assign in_data        = in_data_q;
    assign out_overflow   = overflow_q;

    // A full FIFO still takes the word if the host pops in the same cycle.
    assign out_accept = out_signal && (!out_full || host_out_ready);

    always_comb begin
        state_d   = state_q;
        in_data_d = in_data_q;
        in_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_req) begin
                    if (!in_empty) begin
                        in_pop    = 1'b1;
                        in_data_d = in_head;
                        state_d   = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (halt) begin
                    state_d = IDLE;
                end else if (!in_empty) begin
                    in_pop    = 1'b1;
                    in_data_d = in_head;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            in_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_data_q <= in_data_d;
            if (out_signal && !out_accept) overflow_q <= 1'b1;
        end
    end

`ifdef IO_BRIDGE_STATS_EN
    logic [31:0] out_cnt_q, in_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_cnt_q <= '0;
            in_cnt_q  <= '0;
        end else begin
            if (out_accept) out_cnt_q <= out_cnt_q + 32'd1;
            if (in_signal)  in_cnt_q  <= in_cnt_q + 32'd1;
        end
    end

    assign out_word_count = out_cnt_q;
    assign in_word_count  = in_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_io_bridge.sv
// tb_cpu_io_bridge: directed self-checking bench for cpu_io_bridge (WIDTH=64, DEPTH=8).
module tb_cpu_io_bridge;

    localparam int unsigned WIDTH = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             out_signal;
    logic [WIDTH-1:0] out_data;
    logic             in_req;
    logic             in_signal;
    logic [WIDTH-1:0] in_data;
    logic             halt;
    logic             host_out_valid;
    logic [WIDTH-1:0] host_out_data;
    logic             host_out_ready;
    logic             host_in_valid;
    logic [WIDTH-1:0] host_in_data;
    logic             host_in_ready;
    logic             out_overflow;
`ifdef IO_BRIDGE_STATS_EN
    logic [31:0]      out_word_count;
    logic [31:0]      in_word_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cpu_io_bridge #(
        .WIDTH(WIDTH),
        .DEPTH(8)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .out_signal    (out_signal),
        .out_data      (out_data),
        .in_req        (in_req),
        .in_signal     (in_signal),
        .in_data       (in_data),
        .halt          (halt),
        .host_out_valid(host_out_valid),
        .host_out_data (host_out_data),
        .host_out_ready(host_out_ready),
        .host_in_valid (host_in_valid),
        .host_in_data  (host_in_data),
        .host_in_ready (host_in_ready),
`ifdef IO_BRIDGE_STATS_EN
        .out_word_count(out_word_count),
        .in_word_count (in_word_count),
`endif
        .out_overflow  (out_overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge; sample and drive 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_out(input logic [63:0] w);
        out_signal = 1'b1;
        out_data   = w;
        tick();
        out_signal = 1'b0;
    endtask

    task automatic host_push(input logic [63:0] w);
        host_in_valid = 1'b1;
        host_in_data  = w;
        tick();
        host_in_valid = 1'b0;
    endtask

    task automatic cpu_req();
        in_req = 1'b1;
        tick();
        in_req = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        out_signal     = 1'b0;
        out_data       = '0;
        in_req         = 1'b0;
        halt           = 1'b0;
        host_out_ready = 1'b0;
        host_in_valid  = 1'b0;
        host_in_data   = '0;
        tick();
        tick();
        check("rst_in_signal", in_signal, 0);
        check("rst_in_data", in_data, 0);
        check("rst_out_valid", host_out_valid, 0);
        check("rst_out_data", host_out_data, 0);
        check("rst_in_ready", host_in_ready, 1);
        check("rst_overflow", out_overflow, 0);
        reset = 1'b0;
        tick();

        // Output path: three words, then drain in order.
        cpu_out(5);
        check("out_first_valid", host_out_valid, 1);
        check("out_first_head", host_out_data, 5);
        cpu_out(7);
        cpu_out(9);
        host_out_ready = 1'b1;
        check("drain_0", host_out_data, 5);
        tick();
        check("drain_1", host_out_data, 7);
        tick();
        check("drain_2", host_out_data, 9);
        tick();
        check("drain_empty", host_out_valid, 0);
        check("no_overflow", out_overflow, 0);
        host_out_ready = 1'b0;

        // Overflow: nine words into eight slots.
        for (int i = 1; i <= 9; i++) cpu_out(64'(i));
        check("overflow_set", out_overflow, 1);
        host_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("ovf_drain_valid", host_out_valid, 1);
            check("ovf_drain_data", host_out_data, 64'(i));
            tick();
        end
        check("ovf_drain_empty", host_out_valid, 0);
        host_out_ready = 1'b0;

        // Push while full with a simultaneous pop is accepted.
        for (int i = 10; i <= 17; i++) cpu_out(64'(i));
        host_out_ready = 1'b1;
        cpu_out(18);
        check("full_pop_push_head", host_out_data, 11);
        for (int i = 11; i <= 18; i++) begin
            check("full_pop_drain", host_out_data, 64'(i));
            tick();
        end
        check("full_pop_empty", host_out_valid, 0);
        check("overflow_sticky", out_overflow, 1);
        host_out_ready = 1'b0;

        // Input path with data present: one-cycle response.
        host_push(42);
        check("in_ready_after_push", host_in_ready, 1);
        cpu_req();
        check("resp_42_signal", in_signal, 1);
        check("resp_42_data", in_data, 42);
        tick();
        check("resp_42_low", in_signal, 0);
        check("resp_42_hold", in_data, 42);

        // Request on empty FIFO waits; a second request in WAIT is ignored.
        cpu_req();
        check("wait_no_resp", in_signal, 0);
        tick();
        cpu_req();
        check("wait_second_req", in_signal, 0);
        host_push(100);
        check("wait_push_edge", in_signal, 0);
        tick();
        check("wait_resp_signal", in_signal, 1);
        check("wait_resp_data", in_data, 100);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_no_extra", in_signal, 0);
        end

        // Halt abandons the pending request.
        cpu_req();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        host_push(5);
        check("halt_no_resp_a", in_signal, 0);
        tick();
        check("halt_no_resp_b", in_signal, 0);
        cpu_req();
        check("halt_new_req_signal", in_signal, 1);
        check("halt_new_req_data", in_data, 5);
        tick();
        check("halt_new_req_low", in_signal, 0);

        // Reset with words buffered in both FIFOs.
        for (int i = 0; i < 3; i++) begin
            out_signal    = 1'b1;
            out_data      = 64'(200 + i);
            host_in_valid = 1'b1;
            host_in_data  = 64'(300 + i);
            tick();
        end
        out_signal    = 1'b0;
        host_in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_out_valid", host_out_valid, 0);
        check("mid_rst_in_signal", in_signal, 0);
        check("mid_rst_overflow", out_overflow, 0);
        check("mid_rst_in_ready", host_in_ready, 1);
        check("mid_rst_in_data", in_data, 0);
`ifdef IO_BRIDGE_STATS_EN
        check("mid_rst_out_count", out_word_count, 0);
        check("mid_rst_in_count", in_word_count, 0);
`endif
        // Input FIFO was flushed: request must wait.
        cpu_req();
        check("flushed_in_fifo", in_signal, 0);

        // Reset with WAIT pending clears the request.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        host_push(77);
        check("rst_wait_a", in_signal, 0);
        tick();
        check("rst_wait_b", in_signal, 0);
        cpu_req();
        check("post_rst_resp_signal", in_signal, 1);
        check("post_rst_resp_data", in_data, 77);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
